// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter
//   Round-robin arbiter that shares one downstream single-cycle req/ack
//   responder among N_REQ level-requesting clients. Only one transaction is
//   outstanding at a time: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//
// Parameters
//   N_REQ    number of requesters (2..16)
//   TIMEOUT  maximum number of WAIT cycles for the downstream ack (>= 3)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req_i     level requests, bit i belongs to requester i
//   ack_o     one-cycle completion pulse to the granted requester
//   err_o     one-cycle timeout pulse to the granted requester
//   grant_o   one-hot current owner, zero when idle
//   dn_req_o  one-cycle request pulse to the downstream responder
//   dn_ack_i  downstream ack pulse (honoured only in WAIT)
//   busy_o    high whenever the arbiter is not idle
module req_ack_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] ack_o,
  output logic [N_REQ-1:0] err_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             dn_req_o,
  input  logic             dn_ack_i,
  output logic             busy_o
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic           found;
  logic [IW-1:0]  winner;
  int unsigned    scan;
  logic           hit;
  logic [N_REQ-1:0] gnt_onehot;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = 32'(last_q) + 32'd1 + i;
      if (scan >= N_REQ) begin
        scan = scan - N_REQ;
      end
      if (!found && req_i[IW'(scan)]) begin
        found  = 1'b1;
        winner = IW'(scan);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_idx_d = gnt_idx_q;
    timer_d   = timer_q;
    hit       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_idx_d = winner;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ack is tested first so a last-cycle ack beats the timeout.
        if (dn_ack_i) begin
          hit     = 1'b1;
          state_d = S_RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RELEASE: begin
        last_d  = gnt_idx_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_d;
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so each output reflects the state it is registered with, flop-direct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(N_REQ - 1);
      gnt_idx_q <= '0;
      timer_q   <= '0;
      grant_o   <= '0;
      ack_o     <= '0;
      err_o     <= '0;
      dn_req_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_idx_q <= gnt_idx_d;
      timer_q   <= timer_d;
      grant_o   <= (state_d != S_IDLE) ? gnt_onehot : '0;
      ack_o     <= (state_d == S_RELEASE && hit)  ? gnt_onehot : '0;
      err_o     <= (state_d == S_RELEASE && !hit) ? gnt_onehot : '0;
      dn_req_o  <= (state_d == S_ISSUE);
      busy_o    <= (state_d != S_IDLE);
    end
  end

endmodule
